// File: rtl/regfile_pair_gen.sv
// Byte register file with even/odd pair operations (add constant, move, swap)
// and carry/zero flags from the pair add. Reads are combinational.
module regfile_pair_gen #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 16,
    parameter int CONST_W  = 9,
    parameter int BYPASS   = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_REGS)-1:0]   wr_sel,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic [$clog2(NUM_REGS)-1:0]   a_sel,
    input  logic [$clog2(NUM_REGS)-1:0]   b_sel,
    input  logic [1:0]                    pair_op,
    input  logic [CONST_W-1:0]            constant,
    output logic [DATA_W-1:0]             out_a,
    output logic [DATA_W-1:0]             out_b,
    output logic [DATA_W-1:0]             out_c,
    output logic [2*DATA_W-1:0]           out_pair_a,
    output logic                          pair_carry,
    output logic                          pair_zero
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int PW = 2 * DATA_W;

    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_MOVE = 2'b10;
    localparam logic [1:0] OP_SWAP = 2'b11;

    logic [DATA_W-1:0] r_rf [NUM_REGS];
    logic              r_carry;
    logic              r_zero;

    logic [DATA_W-1:0] w_rf_next [NUM_REGS];
    logic [AW-2:0]     w_pa;
    logic [AW-2:0]     w_pb;
    logic [PW-1:0]     w_pair_a;
    logic [PW-1:0]     w_pair_b;
    logic [PW-1:0]     w_const_ext;
    logic [PW:0]       w_sum;
    logic [PW-1:0]     w_add_res;

    assign w_pa        = a_sel[AW-1:1];
    assign w_pb        = b_sel[AW-1:1];
    assign w_pair_a    = {r_rf[{w_pa, 1'b1}], r_rf[{w_pa, 1'b0}]};
    assign w_pair_b    = {r_rf[{w_pb, 1'b1}], r_rf[{w_pb, 1'b0}]};
    assign w_const_ext = PW'($signed(constant));
    assign w_sum       = {1'b0, w_pair_b} + {1'b0, w_const_ext};
    assign w_add_res   = w_sum[PW-1:0];

    // Per-register next value: pair op result first, then a byte write overrides its own byte.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            localparam logic [AW-2:0] PIDX = (AW-1)'(gi / 2);
            localparam logic [AW-1:0] RIDX = AW'(gi);
            localparam int            LO   = (gi % 2) * DATA_W;
            logic [DATA_W-1:0] w_next;

            always_comb begin
                w_next = r_rf[gi];
                case (pair_op)
                    OP_ADD: begin
                        if (w_pb == PIDX) w_next = w_add_res[LO +: DATA_W];
                    end
                    OP_MOVE: begin
                        if (w_pa == PIDX) w_next = w_pair_b[LO +: DATA_W];
                    end
                    OP_SWAP: begin
                        if (w_pa == PIDX)      w_next = w_pair_b[LO +: DATA_W];
                        else if (w_pb == PIDX) w_next = w_pair_a[LO +: DATA_W];
                    end
                    default: ;
                endcase
                if (wr_en && wr_sel == RIDX) w_next = wr_data;
            end

            assign w_rf_next[gi] = w_next;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_rf[i] <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) r_rf[i] <= w_rf_next[i];
            if (pair_op == OP_ADD) begin
                r_carry <= w_sum[PW];
                r_zero  <= (w_add_res == '0);
            end
        end
    end

    // Only the byte ports forward a same-cycle write; pair views always show stored state.
    assign out_a      = (BYPASS != 0 && wr_en && wr_sel == a_sel) ? wr_data : r_rf[a_sel];
    assign out_b      = (BYPASS != 0 && wr_en && wr_sel == b_sel) ? wr_data : r_rf[b_sel];
    assign out_c      = r_rf[{w_pb, 1'b1}];
    assign out_pair_a = w_pair_a;
    assign pair_carry = r_carry;
    assign pair_zero  = r_zero;
endmodule

// File: tb/tb_regfile_pair_gen.sv
// Drives an 8-bit/16-reg bypassing build and a 16-bit/32-reg non-bypassing build with the
// same stimulus and compares both against a whole-pair arithmetic model.
module tb_regfile_pair_gen;
    localparam logic [1:0] NONE = 2'b00, ADD = 2'b01, MOVE = 2'b10, SWAP = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  s_ws, s_as, s_bs;
    logic [15:0] s_wd;
    logic [1:0]  s_op;
    logic [11:0] s_c;

    logic [7:0]  o0_a, o0_b, o0_c;
    logic [15:0] o0_p;
    logic        o0_cy, o0_z;
    logic [15:0] o1_a, o1_b, o1_c;
    logic [31:0] o1_p;
    logic        o1_cy, o1_z;

    always #5 clk = ~clk;

    regfile_pair_gen #(.DATA_W(8), .NUM_REGS(16), .CONST_W(9), .BYPASS(1)) u_dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(s_ws[3:0]), .wr_data(s_wd[7:0]),
        .a_sel(s_as[3:0]), .b_sel(s_bs[3:0]), .pair_op(s_op), .constant(s_c[8:0]),
        .out_a(o0_a), .out_b(o0_b), .out_c(o0_c), .out_pair_a(o0_p),
        .pair_carry(o0_cy), .pair_zero(o0_z)
    );

    regfile_pair_gen #(.DATA_W(16), .NUM_REGS(32), .CONST_W(12), .BYPASS(0)) u_dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(s_ws), .wr_data(s_wd),
        .a_sel(s_as), .b_sel(s_bs), .pair_op(s_op), .constant(s_c),
        .out_a(o1_a), .out_b(o1_b), .out_c(o1_c), .out_pair_a(o1_p),
        .pair_carry(o1_cy), .pair_zero(o1_z)
    );

    logic [31:0] ob_a [2], ob_b [2], ob_c [2], ob_p [2];
    logic        ob_cy [2], ob_z [2];
    assign ob_a[0] = 32'(o0_a);  assign ob_a[1] = 32'(o1_a);
    assign ob_b[0] = 32'(o0_b);  assign ob_b[1] = 32'(o1_b);
    assign ob_c[0] = 32'(o0_c);  assign ob_c[1] = 32'(o1_c);
    assign ob_p[0] = 32'(o0_p);  assign ob_p[1] = o1_p;
    assign ob_cy[0] = o0_cy;     assign ob_cy[1] = o1_cy;
    assign ob_z[0]  = o0_z;      assign ob_z[1]  = o1_z;

    // Reference model: per build, register bytes and flags as plain integers.
    longint m_rf [2][32];
    bit     m_cy [2];
    bit     m_z  [2];
    int     cfg_dw  [2] = '{8, 16};
    int     cfg_nr  [2] = '{16, 32};
    int     cfg_cw  [2] = '{9, 12};
    int     cfg_byp [2] = '{1, 0};

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint pair_val(int k, int p);
        return (m_rf[k][2*p+1] << cfg_dw[k]) | m_rf[k][2*p];
    endfunction

    task automatic set_pair(int k, int p, longint v);
        longint mask = (64'd1 << cfg_dw[k]) - 1;
        m_rf[k][2*p]   = v & mask;
        m_rf[k][2*p+1] = (v >> cfg_dw[k]) & mask;
    endtask

    task automatic model_step(int k);
        int     nr   = cfg_nr[k];
        int     dw   = cfg_dw[k];
        int     cw   = cfg_cw[k];
        longint pmod = 64'd1 << (2 * dw);
        int     pa   = (int'(s_as) % nr) / 2;
        int     pb   = (int'(s_bs) % nr) / 2;
        longint va   = pair_val(k, pa);
        longint vb   = pair_val(k, pb);
        longint c    = longint'(s_c) & ((64'd1 << cw) - 1);
        longint sum;
        if (reset) begin
            for (int i = 0; i < 32; i++) m_rf[k][i] = 0;
            m_cy[k] = 0;
            m_z[k]  = 0;
            return;
        end
        if (c >= (64'd1 << (cw - 1))) c = c - (64'd1 << cw);
        c = ((c % pmod) + pmod) % pmod;
        sum = vb + c;
        case (s_op)
            ADD: begin
                set_pair(k, pb, sum % pmod);
                m_cy[k] = (sum >= pmod);
                m_z[k]  = (sum % pmod) == 0;
            end
            MOVE: set_pair(k, pa, vb);
            SWAP: begin
                set_pair(k, pa, vb);
                set_pair(k, pb, va);
            end
            default: ;
        endcase
        if (wr_en) m_rf[k][int'(s_ws) % nr] = longint'(s_wd) & ((64'd1 << dw) - 1);
    endtask

    task automatic check_all(int k);
        int     nr   = cfg_nr[k];
        longint mask = (64'd1 << cfg_dw[k]) - 1;
        int     a    = int'(s_as) % nr;
        int     b    = int'(s_bs) % nr;
        int     w    = int'(s_ws) % nr;
        longint wd   = longint'(s_wd) & mask;
        longint ea   = (cfg_byp[k] != 0 && wr_en && w == a) ? wd : m_rf[k][a];
        longint eb   = (cfg_byp[k] != 0 && wr_en && w == b) ? wd : m_rf[k][b];
        check_val($sformatf("d%0d.out_a", k), ob_a[k], 32'(ea));
        check_val($sformatf("d%0d.out_b", k), ob_b[k], 32'(eb));
        check_val($sformatf("d%0d.out_c", k), ob_c[k], 32'(m_rf[k][(b/2)*2+1]));
        check_val($sformatf("d%0d.out_pair_a", k), ob_p[k], 32'(pair_val(k, a/2)));
        check_val($sformatf("d%0d.carry", k), 32'(ob_cy[k]), 32'(m_cy[k]));
        check_val($sformatf("d%0d.zero", k), 32'(ob_z[k]), 32'(m_z[k]));
    endtask

    task automatic drive(input logic r, input logic we, input logic [4:0] ws,
                         input logic [15:0] wd, input logic [4:0] as, input logic [4:0] bs,
                         input logic [1:0] op, input logic [11:0] c);
        @(negedge clk);
        reset = r; wr_en = we; s_ws = ws; s_wd = wd;
        s_as = as; s_bs = bs; s_op = op; s_c = c;
        #1;
    endtask

    // Compare both builds against the model, then take the edge and advance the model.
    task automatic settle();
        check_all(0);
        check_all(1);
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic apply(input logic r, input logic we, input logic [4:0] ws,
                         input logic [15:0] wd, input logic [4:0] as, input logic [4:0] bs,
                         input logic [1:0] op, input logic [11:0] c);
        drive(r, we, ws, wd, as, bs, op, c);
        settle();
        $display("vec r=%0b we=%0b ws=%0d wd=%h a=%0d b=%0d op=%0d c=%h | d0 a=%h p=%h cy=%0b z=%0b",
                 r, we, ws, wd, as, bs, op, c, o0_a, o0_p, o0_cy, o0_z);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) m_rf[k][i] = 0;
            m_cy[k] = 0;
            m_z[k]  = 0;
        end
        reset = 1'b1; wr_en = 1'b0; s_ws = '0; s_wd = '0;
        s_as = '0; s_bs = '0; s_op = NONE; s_c = '0;
        @(posedge clk);
        #1;
        apply(1, 0, 0, 0, 0, 0, NONE, 0);
        check_val("rst_pair0", 32'(o0_p), 32'h0);
        check_val("rst_carry1", 32'(o1_cy), 32'h0);

        // Byte write then read back
        apply(0, 1, 3, 16'h00A5, 3, 0, NONE, 0);
        apply(0, 0, 0, 0, 3, 0, NONE, 0);
        check_val("t1_out_a0", 32'(o0_a), 32'hA5);
        check_val("t1_out_a1", 32'(o1_a), 32'hA5);
        check_val("t1_out_b0", 32'(o0_b), 32'h0);

        // Pair add with carry and zero, flags hold afterwards
        apply(0, 1, 4, 16'h00FF, 4, 4, NONE, 0);
        apply(0, 0, 0, 0, 4, 4, ADD, 12'h001);
        check_val("t2_add1_pair", 32'(o0_p), 32'h0100);
        check_val("t2_add1_cy", 32'(o0_cy), 32'h0);
        check_val("t2_add1_z", 32'(o0_z), 32'h0);
        apply(0, 0, 0, 0, 4, 4, ADD, 12'hF00);
        check_val("t2_sub_pair", 32'(o0_p), 32'h0000);
        check_val("t2_sub_cy", 32'(o0_cy), 32'h1);
        check_val("t2_sub_z", 32'(o0_z), 32'h1);
        check_val("t2_sub_cy1", 32'(o1_cy), 32'h1);
        for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 4, 4, NONE, 0);
        check_val("t2_hold_cy", 32'(o0_cy), 32'h1);
        check_val("t2_hold_z", 32'(o0_z), 32'h1);

        // Swap and move
        apply(0, 1, 0, 16'h0034, 0, 0, NONE, 0);
        apply(0, 1, 1, 16'h0012, 0, 0, NONE, 0);
        apply(0, 1, 6, 16'h00EF, 0, 0, NONE, 0);
        apply(0, 1, 7, 16'h00BE, 0, 0, NONE, 0);
        apply(0, 0, 0, 0, 0, 7, SWAP, 0);
        check_val("t3_swap_a", 32'(o0_p), 32'hBEEF);
        check_val("t3_swap_c", 32'(o0_c), 32'h12);
        apply(0, 0, 0, 0, 2, 0, MOVE, 0);
        check_val("t3_move", 32'(o0_p), 32'hBEEF);

        // Byte write inside the pair being added
        apply(0, 1, 8, 16'h00FE, 8, 8, NONE, 0);
        apply(0, 1, 9, 16'h0010, 8, 8, NONE, 0);
        apply(0, 1, 8, 16'h0055, 9, 8, ADD, 12'h003);
        check_val("t4_pair", 32'(o0_c), 32'h11);
        check_val("t4_cy", 32'(o0_cy), 32'h0);
        check_val("t4_z", 32'(o0_z), 32'h0);

        // Same-cycle write forwarding on port A
        drive(0, 1, 2, 16'h0077, 2, 0, NONE, 0);
        check_val("t5_byp0", 32'(o0_a), 32'h77);
        check_val("t5_nobyp1", 32'(o1_a), 32'h00EF);
        settle();
        check_val("t5_after1", 32'(o1_a), 32'h0077);

        // Full-width wrap, then reset overriding an add
        apply(0, 1, 4, 16'hFFFF, 4, 4, NONE, 0);
        apply(0, 1, 5, 16'hFFFF, 4, 4, NONE, 0);
        apply(0, 0, 0, 0, 4, 4, ADD, 12'h001);
        check_val("t6_wrap_p1", o1_p, 32'h0);
        check_val("t6_wrap_cy1", 32'(o1_cy), 32'h1);
        apply(0, 1, 4, 16'h0001, 4, 4, NONE, 0);
        apply(1, 0, 0, 0, 4, 4, ADD, 12'h001);
        check_val("t6_rst_p0", 32'(o0_p), 32'h0);
        check_val("t6_rst_cy0", 32'(o0_cy), 32'h0);
        check_val("t6_rst_z1", 32'(o1_z), 32'h0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            apply(($urandom_range(0, 49) == 0), 1'($urandom), 5'($urandom), 16'($urandom),
                  5'($urandom), 5'($urandom), 2'($urandom), 12'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
